bch_gf_mul_ds: RTL and testbench

BCH_GF_MUL_DS -- requirements
Module: bch_gf_mul_ds

---
 rtl/bch_gf_mul_ds.sv | 124 ++++++++++++
 tb/tb_bch_gf_mul_ds.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bch_gf_mul_ds.sv
// Digit-serial GF(2^m) multiplier/squarer, polynomial basis, MSB-first Horner accumulation.
// Latency: result valid exactly C_M/C_DIGIT cycles after the accepting edge, independent of data.
// Backpressure: O_ready low while busy; the result holds in DONE until I_prod_rdy is seen high.
module bch_gf_mul_ds #(
    parameter int             C_M         = 13,
    parameter logic [C_M-1:0] C_POLY_PRIM = 13'h001B,
    parameter int             C_DIGIT     = 1
) (
    input  logic           I_clk,
    input  logic           I_rst,
    input  logic [C_M-1:0] I_a,
    input  logic [C_M-1:0] I_b,
    input  logic           I_mode,
    input  logic           I_valid,
    output logic           O_ready,
    output logic [C_M-1:0] O_prod,
    output logic           O_prod_v,
    input  logic           I_prod_rdy
);

    // Guard against a divide by zero so the parameter check below is the one that reports.
    localparam int N     = (C_DIGIT >= 1) ? (C_M / C_DIGIT) : 1;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    // The digit must tile the field width exactly, otherwise the last digit would be ragged.
    generate
        if ((C_DIGIT < 1) || (C_DIGIT > C_M) || ((C_M % C_DIGIT) != 0)) begin : g_bad_param
            $error("bch_gf_mul_ds: C_DIGIT must be in 1..C_M and divide C_M");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [C_M-1:0]   a_q;
    logic [C_M-1:0]   b_q;
    logic [C_M-1:0]   acc_q;
    logic [C_M-1:0]   prod_q;
    logic [CNT_W-1:0] cnt_q;
    logic [C_M-1:0]   acc_step;
    logic [C_M-1:0]   b_step;

    // One clock's worth of Horner steps: acc = acc*x mod p, then add a if the current multiplier MSB is set.
    always_comb begin
        acc_step = acc_q;
        b_step   = b_q;
        for (int i = 0; i < C_DIGIT; i++) begin
            logic fb;
            fb       = acc_step[C_M-1];
            acc_step = acc_step << 1;
            if (fb) begin
                acc_step = acc_step ^ C_POLY_PRIM;
            end
            if (b_step[C_M-1]) begin
                acc_step = acc_step ^ a_q;
            end
            b_step = b_step << 1;
        end
    end

    // Next-state decode; operands offered outside IDLE are never considered.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (I_valid)      state_d = S_CALC;
            S_CALC: if (cnt_q == '0)  state_d = S_DONE;
            S_DONE: if (I_prod_rdy)   state_d = S_IDLE;
            default:                  state_d = S_IDLE;
        endcase
    end

    // State register; reset abandons any operation in flight.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture, digit-serial accumulation and result latch.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            prod_q <= '0;
            cnt_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (I_valid) begin
                        a_q   <= I_a;
                        b_q   <= I_mode ? I_a : I_b;
                        acc_q <= '0;
                        cnt_q <= CNT_W'(N - 1);
                    end
                end
                S_CALC: begin
                    acc_q <= acc_step;
                    b_q   <= b_step;
                    if (cnt_q == '0) begin
                        prod_q <= acc_step;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs come straight from registers or the state decode, never from inputs.
    assign O_ready  = (state_q == S_IDLE);
    assign O_prod_v = (state_q == S_DONE);
    assign O_prod   = prod_q;

endmodule

// File: tb/tb_bch_gf_mul_ds.sv
// Directed bench for bch_gf_mul_ds: three GF(2^4) instances (digit 1, 2, 4) share stimulus,
// plus a default GF(2^13) instance checked against an independent LSB-first reference.
// All outputs sampled 1 time unit after the rising edge; inputs driven at the same point.
module tb_bch_gf_mul_ds;

    logic       I_clk = 1'b0;
    logic       rst;
    logic [3:0] a, b;
    logic       mode, valid, prdy;
    logic       rdy1, rdy2, rdy4, pv1, pv2, pv4;
    logic [3:0] p1, p2, p4;

    logic [12:0] a13, b13, p13;
    logic        mode13, valid13, prdy13, rdy13, pv13;

    int n_vec = 0;
    int n_err = 0;

    always #5 I_clk = ~I_clk;

    bch_gf_mul_ds #(.C_M(4), .C_POLY_PRIM(4'h3), .C_DIGIT(1)) u_d1 (
        .I_clk(I_clk), .I_rst(rst), .I_a(a), .I_b(b), .I_mode(mode), .I_valid(valid),
        .O_ready(rdy1), .O_prod(p1), .O_prod_v(pv1), .I_prod_rdy(prdy));

    bch_gf_mul_ds #(.C_M(4), .C_POLY_PRIM(4'h3), .C_DIGIT(2)) u_d2 (
        .I_clk(I_clk), .I_rst(rst), .I_a(a), .I_b(b), .I_mode(mode), .I_valid(valid),
        .O_ready(rdy2), .O_prod(p2), .O_prod_v(pv2), .I_prod_rdy(prdy));

    bch_gf_mul_ds #(.C_M(4), .C_POLY_PRIM(4'h3), .C_DIGIT(4)) u_d4 (
        .I_clk(I_clk), .I_rst(rst), .I_a(a), .I_b(b), .I_mode(mode), .I_valid(valid),
        .O_ready(rdy4), .O_prod(p4), .O_prod_v(pv4), .I_prod_rdy(prdy));

    bch_gf_mul_ds u_d13 (
        .I_clk(I_clk), .I_rst(rst), .I_a(a13), .I_b(b13), .I_mode(mode13), .I_valid(valid13),
        .O_ready(rdy13), .O_prod(p13), .O_prod_v(pv13), .I_prod_rdy(prdy13));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Shift-and-add from the multiplier LSB, reducing the shifted multiplicand each step.
    function automatic logic [12:0] gf_ref(input logic [12:0] x, input logic [12:0] y,
                                           input int m, input logic [12:0] poly);
        logic [12:0] r, aa, mask;
        r    = '0;
        aa   = x;
        mask = 13'((1 << m) - 1);
        for (int i = 0; i < m; i++) begin
            if (y[i]) r = r ^ aa;
            if (aa[m-1]) aa = ((aa << 1) & mask) ^ poly;
            else         aa = (aa << 1) & mask;
        end
        return r;
    endfunction

    // Offer one operand set to the three GF(2^4) instances and check first-valid latency and product.
    task automatic run_small(input logic [3:0] ta, input logic [3:0] tb, input logic tm,
                             input logic [3:0] exp, input string tag);
        int l1, l2, l4;
        logic [3:0] q1, q2, q4;
        chk({tag, "_rdy"}, {31'd0, rdy1}, 32'd1);
        a = ta; b = tb; mode = tm; valid = 1'b1;
        @(posedge I_clk); #1;
        valid = 1'b0; a = ~ta; b = ~tb; mode = ~tm;
        l1 = -1; l2 = -1; l4 = -1;
        q1 = 'x; q2 = 'x; q4 = 'x;
        for (int c = 1; c <= 12 && l1 < 0; c++) begin
            @(posedge I_clk); #1;
            if (pv1 && l1 < 0) begin l1 = c; q1 = p1; end
            if (pv2 && l2 < 0) begin l2 = c; q2 = p2; end
            if (pv4 && l4 < 0) begin l4 = c; q4 = p4; end
        end
        chk({tag, "_lat_d1"},  l1, 32'd4);
        chk({tag, "_prod_d1"}, {28'd0, q1}, {28'd0, exp});
        chk({tag, "_lat_d2"},  l2, 32'd2);
        chk({tag, "_prod_d2"}, {28'd0, q2}, {28'd0, exp});
        chk({tag, "_lat_d4"},  l4, 32'd1);
        chk({tag, "_prod_d4"}, {28'd0, q4}, {28'd0, exp});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen, lat, s;
        logic [12:0] exp13;

        rst = 1'b1; a = '0; b = '0; mode = 1'b0; valid = 1'b0; prdy = 1'b1;
        a13 = '0; b13 = '0; mode13 = 1'b0; valid13 = 1'b0; prdy13 = 1'b0;
        #12;
        chk("rst_rdy",    {31'd0, rdy1},  32'd1);
        chk("rst_pv",     {31'd0, pv1},   32'd0);
        chk("rst_prod",   {28'd0, p1},    32'd0);
        chk("rst_rdy13",  {31'd0, rdy13}, 32'd1);
        chk("rst_pv13",   {31'd0, pv13},  32'd0);
        chk("rst_prod13", {19'd0, p13},   32'd0);
        @(posedge I_clk); #1;
        rst = 1'b0;

        // x * x^3 = x^4 = x + 1
        run_small(4'h2, 4'h8, 1'b0, 4'h3, "mul_2_8");  @(posedge I_clk); #1;
        // (x+1)(x^2+x+1) = x^3 + 1
        run_small(4'h3, 4'h7, 1'b0, 4'h9, "mul_3_7");  @(posedge I_clk); #1;
        // square of x^3 = x^6 = x^3 + x^2, I_b ignored
        run_small(4'h8, 4'hF, 1'b1, 4'hC, "sq_8");     @(posedge I_clk); #1;
        // (x^3+x^2+x+1)^2 = x^3 + x
        run_small(4'hF, 4'hF, 1'b0, 4'hA, "mul_f_f");  @(posedge I_clk); #1;
        run_small(4'h0, 4'h5, 1'b0, 4'h0, "zero_a");   @(posedge I_clk); #1;
        run_small(4'h6, 4'h0, 1'b0, 4'h0, "zero_b");   @(posedge I_clk); #1;

        // Backpressure in DONE with operand pulses that must be ignored.
        prdy = 1'b0;
        run_small(4'h2, 4'h8, 1'b0, 4'h3, "bp");
        for (int k = 0; k < 5; k++) begin
            valid = 1'b1; a = 4'h5; b = 4'h5;
            @(posedge I_clk); #1;
            chk("bp_pv",   {31'd0, pv1},  32'd1);
            chk("bp_prod", {28'd0, p1},   32'd3);
            chk("bp_rdy",  {31'd0, rdy1}, 32'd0);
        end
        prdy = 1'b1;
        @(posedge I_clk); #1;
        chk("rel_rdy",  {31'd0, rdy1}, 32'd1);
        chk("rel_pv",   {31'd0, pv1},  32'd0);
        chk("rel_prod", {28'd0, p1},   32'd3);
        valid = 1'b0;
        @(posedge I_clk); #1;

        // Reset during the second CALC cycle discards the operation.
        a = 4'h2; b = 4'h8; mode = 1'b0; valid = 1'b1;
        @(posedge I_clk); #1;
        valid = 1'b0;
        @(posedge I_clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_prod", {28'd0, p1},   32'd0);
        chk("midrst_pv",   {31'd0, pv1},  32'd0);
        chk("midrst_rdy",  {31'd0, rdy1}, 32'd1);
        @(posedge I_clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge I_clk); #1;
            if (pv1 || pv2 || pv4) seen++;
        end
        chk("midrst_nopv", seen, 32'd0);
        run_small(4'h2, 4'h8, 1'b0, 4'h3, "after_rst"); @(posedge I_clk); #1;

        // Default GF(2^13) instance against the reference, with random output stalls.
        for (int v = 0; v < 3000; v++) begin
            a13    = 13'($urandom);
            b13    = 13'($urandom);
            mode13 = ($urandom_range(0, 3) == 0);
            exp13  = gf_ref(a13, mode13 ? a13 : b13, 13, 13'h001B);
            valid13 = 1'b1; prdy13 = 1'b0;
            @(posedge I_clk); #1;
            valid13 = 1'b0; a13 = ~a13; b13 = ~b13;
            lat = 0;
            while (!pv13 && lat < 40) begin
                @(posedge I_clk); #1;
                lat++;
            end
            chk($sformatf("r13_lat_%0d", v),  lat, 32'd13);
            chk($sformatf("r13_prod_%0d", v), {19'd0, p13}, {19'd0, exp13});
            s = $urandom_range(0, 2);
            for (int k = 0; k < s; k++) begin
                @(posedge I_clk); #1;
                chk($sformatf("r13_hold_%0d", v), {18'd0, pv13, p13}, {18'd0, 1'b1, exp13});
            end
            prdy13 = 1'b1;
            @(posedge I_clk); #1;
            prdy13 = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
